// File: rtl/clk_gate_ctrl_if.sv
// Signal bundle between the clock-gate controller and the domain it gates.
// The master modport is the controller; the slave modport is the gated domain and its activity sources.
interface clk_gate_ctrl_if;
    logic busy;
    logic wake_req;
    logic force_on;
    logic sleep_ack;
    logic clk_ce;
    logic sleep_req;
    logic gated;

    modport master (
        input  busy,
        input  wake_req,
        input  force_on,
        input  sleep_ack,
        output clk_ce,
        output sleep_req,
        output gated
    );

    modport slave (
        output busy,
        output wake_req,
        output force_on,
        output sleep_ack,
        input  clk_ce,
        input  sleep_req,
        input  gated
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Idle-detect clock-gate controller in the free-running domain.
// Runs a sleep_req/sleep_ack handshake before dropping the BUFGCE enable, and a fixed settle window after raising it.
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    clk_gate_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REQ   = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_wake_cnt;
    logic             r_clk_ce;
    logic             r_sleep_req;
    logic             r_gated;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_idle_next;
    logic [CNT_W-1:0] w_wake_next;
    logic             w_clk_ce_next;
    logic             w_sleep_req_next;
    logic             w_gated_next;
    logic             w_act;

    assign w_act = bus.busy | bus.wake_req | bus.force_on;

    // NOTE: every signal gets a default before the case so that no path leaves it unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_idle_next  = r_idle_cnt;
        w_wake_next  = r_wake_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_act) begin
                    w_idle_next = '0;
                end else if (r_idle_cnt >= IDLE_LAST) begin
                    w_state_next = ST_REQ;
                    w_idle_next  = '0;
                end else begin
                    w_idle_next = r_idle_cnt + 1'b1;
                end
            end
            ST_REQ: begin
                w_idle_next = '0;
                // Activity wins over an acknowledge arriving in the same cycle.
                if (w_act) begin
                    w_state_next = ST_RUN;
                end else if (bus.sleep_ack) begin
                    w_state_next = ST_GATED;
                end
            end
            ST_GATED: begin
                if (w_act) begin
                    w_state_next = ST_WAKE;
                    w_wake_next  = WAKE_LAST;
                end
            end
            ST_WAKE: begin
                w_idle_next = '0;
                if (r_wake_cnt == '0) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_wake_next = r_wake_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = ST_RUN;
                w_idle_next  = '0;
                w_wake_next  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so clk_ce only ever changes from a flop.
    always_comb begin
        w_clk_ce_next    = (w_state_next != ST_GATED);
        w_sleep_req_next = (w_state_next != ST_RUN);
        w_gated_next     = (w_state_next == ST_GATED);
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block and all state uses non-blocking assignments.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_idle_cnt  <= '0;
            r_wake_cnt  <= '0;
            r_clk_ce    <= 1'b1;
            r_sleep_req <= 1'b0;
            r_gated     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idle_cnt  <= w_idle_next;
            r_wake_cnt  <= w_wake_next;
            r_clk_ce    <= w_clk_ce_next;
            r_sleep_req <= w_sleep_req_next;
            r_gated     <= w_gated_next;
        end
    end

    assign bus.clk_ce    = r_clk_ce;
    assign bus.sleep_req = r_sleep_req;
    assign bus.gated     = r_gated;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed scenarios with literal expectations, then a random soak.
// A per-cycle compare checks the DUT against a behavioural model and the gating invariants.
module tb_clk_gate_ctrl;

    localparam int IDLE_CYCLES = 16;
    localparam int WAKE_CYCLES = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    clk_gate_ctrl_if bus ();

    clk_gate_ctrl #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES),
        .CNT_W       (8)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
        end
    endtask

    // Behavioural model: the controller is either awake, requesting sleep, asleep,
    // or counting down a settle window; tracked as flags and counts of samples.
    logic m_valid;
    logic m_req;
    logic m_off;
    int   m_idle;
    int   m_wake_left;
    logic m_last_ack;

    always @(posedge clk) begin
        logic act;
        logic n_req;
        logic n_off;
        int   n_idle;
        int   n_wake;
        act    = bus.busy | bus.wake_req | bus.force_on;
        n_req  = m_req;
        n_off  = m_off;
        n_idle = m_idle;
        n_wake = m_wake_left;
        if (rst) begin
            n_req  = 1'b0;
            n_off  = 1'b0;
            n_idle = 0;
            n_wake = 0;
        end else if (m_wake_left > 0) begin
            n_wake = m_wake_left - 1;
            if (n_wake == 0) n_req = 1'b0;
        end else if (m_off) begin
            if (act) begin
                n_off  = 1'b0;
                n_wake = WAKE_CYCLES;
            end
        end else if (m_req) begin
            if (act) begin
                n_req  = 1'b0;
                n_idle = 0;
            end else if (bus.sleep_ack) begin
                n_off = 1'b1;
            end
        end else begin
            n_idle = act ? 0 : m_idle + 1;
            if (n_idle == IDLE_CYCLES) begin
                n_req  = 1'b1;
                n_idle = 0;
            end
        end
        m_req       <= n_req;
        m_off       <= n_off;
        m_idle      <= n_idle;
        m_wake_left <= n_wake;
        m_last_ack  <= bus.sleep_ack;
        if (rst) m_valid <= 1'b1;
    end

    initial m_valid = 1'b0;

    // Per-cycle compare against the model plus the two gating invariants.
    initial begin
        logic prev_ce;
        prev_ce = 1'b1;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("model_clk_ce", bus.clk_ce, ~m_off);
                check("model_sleep_req", bus.sleep_req, m_req);
                check("model_gated", bus.gated, m_off);
                if (bus.clk_ce === 1'b0) check("inv_ce_low_needs_req", bus.sleep_req, 1'b1);
                if (prev_ce === 1'b1 && bus.clk_ce === 1'b0 && !rst)
                    check("inv_ce_fall_needs_ack", m_last_ack, 1'b1);
                prev_ce = bus.clk_ce;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic ce, input logic req, input logic g);
        check({name, "_clk_ce"}, bus.clk_ce, ce);
        check({name, "_sleep_req"}, bus.sleep_req, req);
        check({name, "_gated"}, bus.gated, g);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.busy      = 1'b0;
        bus.wake_req  = 1'b0;
        bus.force_on  = 1'b0;
        bus.sleep_ack = 1'b0;

        // Reset state
        tick(2);
        expect_out("reset", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        // Idle entry: request after exactly 16 idle samples, gate one edge after the ack
        tick(15);
        check("idle15_sleep_req", bus.sleep_req, 1'b0);
        tick(1);
        expect_out("idle16", 1'b1, 1'b1, 1'b0);
        tick(2);
        check("req_wait_clk_ce", bus.clk_ce, 1'b1);
        bus.sleep_ack = 1'b1;
        tick(1);
        expect_out("gated", 1'b0, 1'b1, 1'b1);
        bus.sleep_ack = 1'b0;
        tick(3);
        expect_out("gated_hold", 1'b0, 1'b1, 1'b1);

        // Wake: one-cycle wake_req pulse, four-cycle settle window
        bus.wake_req = 1'b1;
        tick(1);
        bus.wake_req = 1'b0;
        for (int i = 0; i < WAKE_CYCLES; i++) begin
            expect_out("wake_window", 1'b1, 1'b1, 1'b0);
            tick(1);
        end
        expect_out("wake_done", 1'b1, 1'b0, 1'b0);

        // Abort: activity and ack together in REQ returns to RUN
        tick(15);
        check("reidle15_sleep_req", bus.sleep_req, 1'b0);
        tick(1);
        check("reidle16_sleep_req", bus.sleep_req, 1'b1);
        bus.busy      = 1'b1;
        bus.sleep_ack = 1'b1;
        tick(1);
        expect_out("abort", 1'b1, 1'b0, 1'b0);
        bus.busy      = 1'b0;
        bus.sleep_ack = 1'b0;
        tick(15);
        check("abort_idle15_sleep_req", bus.sleep_req, 1'b0);
        tick(1);
        check("abort_idle16_sleep_req", bus.sleep_req, 1'b1);

        // Reset while gated
        bus.sleep_ack = 1'b1;
        tick(1);
        bus.sleep_ack = 1'b0;
        check("pre_rst_gated", bus.gated, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_out("rst_from_gated", 1'b1, 1'b0, 1'b0);

        // force_on holds the controller awake
        bus.force_on = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("force_on_sleep_req", bus.sleep_req, 1'b0);
        end
        bus.force_on = 1'b0;
        tick(15);
        check("force_rel15_sleep_req", bus.sleep_req, 1'b0);
        tick(1);
        check("force_rel16_sleep_req", bus.sleep_req, 1'b1);

        // Random soak; the compare process checks every cycle
        for (int i = 0; i < 4000; i++) begin
            bus.busy      = ($urandom_range(0, 19) == 0);
            bus.wake_req  = ($urandom_range(0, 39) == 0);
            bus.force_on  = ($urandom_range(0, 99) == 0);
            bus.sleep_ack = ($urandom_range(0, 2) == 0);
            rst           = ($urandom_range(0, 699) == 0);
            tick(1);
        end
        rst           = 1'b0;
        bus.busy      = 1'b0;
        bus.wake_req  = 1'b0;
        bus.force_on  = 1'b0;
        bus.sleep_ack = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
